// File: rtl/keccak_xif_pkg.sv
// Shared types for the Keccak XIF scheduler: FSM states, opcodes and queue entries.
package keccak_xif_pkg;

  // Queue entries carry IDs at this fixed width; the top narrows to ID_W at its ports.
  localparam int unsigned SCHED_ID_W_MAX = 16;

  typedef logic [SCHED_ID_W_MAX-1:0] sched_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STORE,
    ST_WAIT,
    ST_RESP
  } sched_state_t;

  typedef enum logic {
    OP_PERM  = 1'b0,
    OP_STORE = 1'b1
  } sched_op_t;

  typedef struct packed {
    sched_id_t id;
    sched_op_t op;
    logic      committed;
    logic      killed;
  } sched_entry_t;

  function automatic logic entry_unresolved(sched_entry_t e);
    return !(e.committed || e.killed);
  endfunction

endpackage

// File: rtl/keccak_xif_sched_queue.sv
// Circular FIFO of pending instructions with parallel ID-match commit/kill marking.
module keccak_xif_sched_queue
  import keccak_xif_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  sched_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         commit_valid_i,
  input  sched_id_t    commit_id_i,
  input  logic         commit_kill_i,
  output sched_entry_t head_o,
  output logic         empty_o,
  output logic         not_full_o,
  output logic         empty_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [AW-1:0] offs;
  logic          empty_q, not_full_q, full_nxt, empty_nxt;
  sched_entry_t  entry_in;
  sched_entry_t  mem_q [DEPTH];
  sched_entry_t  mem_d [DEPTH];

  assign wptr_d    = wptr_q + (AW+1)'(push_i);
  assign rptr_d    = rptr_q + (AW+1)'(pop_i);
  assign empty_nxt = (wptr_d == rptr_d);
  assign full_nxt  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    count    = wptr_q - rptr_q;
    offs     = '0;
    entry_in = push_entry_i;
    for (int j = 0; j < DEPTH; j++) begin
      mem_d[j] = mem_q[j];
      offs     = AW'(j) - rptr_q[AW-1:0];
      if (commit_valid_i && ({1'b0, offs} < count) && entry_unresolved(mem_q[j]) &&
          (mem_q[j].id == commit_id_i)) begin
        mem_d[j].committed = !commit_kill_i;
        mem_d[j].killed    = commit_kill_i;
      end
    end
    if (commit_valid_i && (push_entry_i.id == commit_id_i)) begin
      entry_in.committed = !commit_kill_i;
      entry_in.killed    = commit_kill_i;
    end
    if (push_i) begin
      mem_d[wptr_q[AW-1:0]] = entry_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      empty_q    <= 1'b1;
      not_full_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      empty_q    <= empty_nxt;
      not_full_q <= !full_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < DEPTH; j++) begin
      mem_q[j] <= mem_d[j];
    end
  end

  assign head_o      = mem_q[rptr_q[AW-1:0]];
  assign empty_o     = empty_q;
  assign not_full_o  = not_full_q;
  assign empty_nxt_o = empty_nxt;

endmodule

// File: rtl/keccak_xif_sched.sv
// Orders committed Keccak offload instructions onto the datapath and returns tagged results.
// Optional WAIT watchdog is compiled in with KECCAK_SCHED_WATCHDOG_EN.
module keccak_xif_sched
  import keccak_xif_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [ID_W-1:0] req_id_i,
  input  logic            req_op_i,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            keccak_start_o,
  output logic            keccak_store_o,
  input  logic            keccak_done_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic            result_err_o,
  output logic            busy_o
);

  sched_state_t    state_q, state_d;
  sched_entry_t    q_head, push_entry;
  logic            q_empty, q_not_full, q_empty_nxt;
  logic            push, pop, wd_expired;
  logic            start_q, store_q, valid_q, busy_q;
  logic [ID_W-1:0] id_q;

  assign push = req_valid_i && q_not_full;

  always_comb begin
    push_entry           = '0;
    push_entry.id        = sched_id_t'(req_id_i);
    push_entry.op        = sched_op_t'(req_op_i);
    push_entry.committed = 1'b0;
    push_entry.killed    = 1'b0;
  end

  keccak_xif_sched_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .commit_valid_i(commit_valid_i),
    .commit_id_i   (sched_id_t'(commit_id_i)),
    .commit_kill_i (commit_kill_i),
    .head_o        (q_head),
    .empty_o       (q_empty),
    .not_full_o    (q_not_full),
    .empty_nxt_o   (q_empty_nxt)
  );

`ifdef KECCAK_SCHED_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q;

  // Counter sits at zero outside WAIT, so it restarts on every entry into WAIT.
  assign wd_cnt_d   = (state_q == ST_WAIT) ? wd_cnt_q + 1'b1 : '0;
  assign wd_expired = (wd_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (state_q == ST_WAIT) begin
        err_q <= (state_d == ST_RESP) && !keccak_done_i;
      end else if (state_d != ST_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  assign result_err_o = err_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign wd_expired     = 1'b0;
  assign result_err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          if (q_head.killed) begin
            pop = 1'b1;
          end else if (q_head.committed) begin
            state_d = (q_head.op == OP_STORE) ? ST_STORE : ST_START;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_STORE: state_d = ST_RESP;
      ST_WAIT: begin
        if (keccak_done_i || wd_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are flopped from next-state so each strobe lands in the cycle its state is entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      store_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      start_q <= (state_d == ST_START);
      store_q <= (state_d == ST_STORE);
      valid_q <= (state_d == ST_RESP);
      busy_q  <= (state_d != ST_IDLE) || !q_empty_nxt;
      if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
        id_q <= ID_W'(q_head.id);
      end
    end
  end

  assign req_ready_o    = q_not_full;
  assign keccak_start_o = start_q;
  assign keccak_store_o = store_q;
  assign result_valid_o = valid_q;
  assign result_id_o    = id_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_keccak_xif_sched.sv
// Directed and randomized bench for keccak_xif_sched with an in-order retirement model.
module tb_keccak_xif_sched;

  localparam int DEPTH   = 4;
  localparam int ID_W    = 4;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b1;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [ID_W-1:0] req_id_i = '0;
  logic            req_op_i = 1'b0;
  logic            commit_valid_i = 1'b0;
  logic [ID_W-1:0] commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            keccak_start_o;
  logic            keccak_store_o;
  logic            keccak_done_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [ID_W-1:0] result_id_o;
  logic            result_err_o;
  logic            busy_o;

  always #5 clk = ~clk;

  keccak_xif_sched #(
    .DEPTH  (DEPTH),
    .ID_W   (ID_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_id_i      (req_id_i),
    .req_op_i      (req_op_i),
    .commit_valid_i(commit_valid_i),
    .commit_id_i   (commit_id_i),
    .commit_kill_i (commit_kill_i),
    .keccak_start_o(keccak_start_o),
    .keccak_store_o(keccak_store_o),
    .keccak_done_i (keccak_done_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_id_o   (result_id_o),
    .result_err_o  (result_err_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    int id;
    int op;
    int res;  // 0 unresolved, 1 committed, 2 killed
  } ment_t;

  int    checks = 0;
  int    failures = 0;
  int    obs_ids[$];
  int    obs_errs[$];
  int    start_cnt = 0;
  int    store_cnt = 0;
  int    done_cnt = 0;
  bit    auto_done = 1'b0;
  int    ready_mode = 0;  // 0 manual, 1 always ready, 2 random
  bit    prev_valid = 1'b0;
  int    prev_id = 0;
  bit    prev_err = 1'b0;
  ment_t model[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Per-cycle bookkeeping: records handshakes, counts strobes, answers starts with done.
  task automatic service();
    if (prev_valid && result_ready_i) begin
      obs_ids.push_back(prev_id);
      obs_errs.push_back(int'(prev_err));
    end
    if (prev_valid && !result_ready_i) begin
      chk("hold_valid", result_valid_o, 1);
      chk("hold_id", result_id_o, prev_id);
    end
    if (auto_done) begin
      keccak_done_i = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) keccak_done_i = 1'b1;
      end
    end
    if (keccak_start_o) begin
      start_cnt++;
      if (auto_done) done_cnt = $urandom_range(1, 6);
    end
    if (keccak_store_o) store_cnt++;
    if (ready_mode == 1) result_ready_i = 1'b1;
    else if (ready_mode == 2) result_ready_i = 1'($urandom_range(0, 1));
    prev_valid = result_valid_o;
    prev_id    = int'(result_id_o);
    prev_err   = result_err_o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    service();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_start"}, keccak_start_o, 0);
    chk({tag, "_store"}, keccak_store_o, 0);
    chk({tag, "_valid"}, result_valid_o, 0);
    chk({tag, "_err"}, result_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_id"}, result_id_o, 0);
  endtask

  task automatic wait_results(input int n, input int bound);
    for (int i = 0; i < bound && obs_ids.size() < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && busy_o !== 1'b0; i++) tick();
    chk(tag, busy_o, 0);
  endtask

  task automatic cmp_ids(input string tag, input int exp[$]);
    chk({tag, "_count"}, obs_ids.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < obs_ids.size()) chk($sformatf("%s_%0d", tag, k), obs_ids[k], exp[k]);
    end
  endtask

  task automatic push_req(input int id, input int op, input bit commit);
    req_valid_i    = 1'b1;
    req_id_i       = ID_W'(id);
    req_op_i       = 1'(op);
    commit_valid_i = commit;
    commit_id_i    = ID_W'(id);
    commit_kill_i  = 1'b0;
    tick();
    req_valid_i    = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic commit_req(input int id, input bit kill);
    commit_valid_i = 1'b1;
    commit_id_i    = ID_W'(id);
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  initial begin
    int exp[$];
    int exp_starts;
    int exp_stores;
    int first;

    #1 rst_ni = 1'b0;
    #1 chk_reset("rst");
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();

    // Single PERM: one start, done 24 cycles later, result held while not accepted.
    start_cnt = 0;
    push_req(3, 0, 1'b0);
    commit_req(3, 1'b0);
    chk("t1_no_start_yet", keccak_start_o, 0);
    tick();
    chk("t1_start", keccak_start_o, 1);
    for (int i = 1; i <= 23; i++) begin
      tick();
      chk("t1_wait_start", keccak_start_o, 0);
      chk("t1_wait_valid", result_valid_o, 0);
    end
    tick();
    keccak_done_i = 1'b1;
    tick();
    keccak_done_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t1_valid", result_valid_o, 1);
      chk("t1_id", result_id_o, 3);
      tick();
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk("t1_valid_drop", result_valid_o, 0);
    chk("t1_busy_drop", busy_o, 0);
    chk("t1_start_cnt", start_cnt, 1);

    // Fill to DEPTH, refuse a fifth push, then retire in order; second round wraps pointers.
    auto_done = 1'b1;
    ready_mode = 1;
    obs_ids.delete();
    for (int i = 1; i <= 4; i++) begin
      push_req(i, 0, 1'b0);
      chk($sformatf("t2_fill_ready_%0d", i), req_ready_o, (i < 4) ? 1 : 0);
    end
    push_req(7, 0, 1'b0);
    chk("t2_full_ready", req_ready_o, 0);
    for (int i = 1; i <= 4; i++) commit_req(i, 1'b0);
    wait_results(4, 400);
    exp = '{1, 2, 3, 4};
    cmp_ids("t2_order", exp);
    wait_idle("t2_idle", 100);
    chk("t2_ready_back", req_ready_o, 1);
    obs_ids.delete();
    for (int i = 8; i <= 11; i++) begin
      for (int w = 0; w < 200 && req_ready_o !== 1'b1; w++) tick();
      push_req(i, 0, 1'b1);
    end
    wait_results(4, 400);
    exp = '{8, 9, 10, 11};
    cmp_ids("t2_wrap", exp);
    wait_idle("t2_wrap_idle", 100);

    // Killed PERM head is dropped silently; committed STORE behind it retires.
    obs_ids.delete();
    start_cnt = 0;
    store_cnt = 0;
    push_req(5, 0, 1'b0);
    push_req(6, 1, 1'b0);
    commit_req(5, 1'b1);
    commit_req(6, 1'b0);
    wait_results(1, 100);
    wait_idle("t3_idle", 100);
    exp = '{6};
    cmp_ids("t3_result", exp);
    chk("t3_starts", start_cnt, 0);
    chk("t3_stores", store_cnt, 1);

    // Commit before push is ignored; entry waits for a later commit.
    obs_ids.delete();
    start_cnt = 0;
    commit_req(9, 1'b0);
    push_req(9, 0, 1'b0);
    repeat (10) tick();
    chk("t4_busy", busy_o, 1);
    chk("t4_no_start", start_cnt, 0);
    chk("t4_no_result", obs_ids.size(), 0);
    commit_req(9, 1'b0);
    wait_results(1, 100);
    exp = '{9};
    cmp_ids("t4_result", exp);
    chk("t4_starts", start_cnt, 1);
    wait_idle("t4_idle", 100);

    // Reset during WAIT clears everything at once; a later done pulse is ignored.
    obs_ids.delete();
    auto_done = 1'b0;
    keccak_done_i = 1'b0;
    done_cnt = 0;
    push_req(12, 0, 1'b1);
    for (int i = 0; i < 20 && keccak_start_o !== 1'b1; i++) tick();
    chk("t5_start_seen", keccak_start_o, 1);
    tick();
    tick();
    rst_ni = 1'b0;
    #1 chk_reset("t5_rst");
    prev_valid = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    keccak_done_i = 1'b1;
    tick();
    keccak_done_i = 1'b0;
    repeat (5) tick();
    chk("t5_no_valid", result_valid_o, 0);
    chk("t5_no_busy", busy_o, 0);
    chk("t5_no_result", obs_ids.size(), 0);

`ifdef KECCAK_SCHED_WATCHDOG_EN
    // Withheld done: watchdog forces RESP TIMEOUT cycles into WAIT with err set.
    ready_mode = 0;
    result_ready_i = 1'b0;
    push_req(13, 0, 1'b1);
    for (int i = 0; i < 20 && keccak_start_o !== 1'b1; i++) tick();
    chk("t6_start_seen", keccak_start_o, 1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("t6_wait_valid", result_valid_o, 0);
    end
    tick();
    chk("t6_valid", result_valid_o, 1);
    chk("t6_err", result_err_o, 1);
    chk("t6_id", result_id_o, 13);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk("t6_err_clear", result_err_o, 0);
    obs_ids.delete();
    obs_errs.delete();
    auto_done = 1'b1;
    ready_mode = 1;
    push_req(14, 0, 1'b1);
    wait_results(1, 100);
    exp = '{14};
    cmp_ids("t6_next", exp);
    if (obs_errs.size() > 0) chk("t6_next_err", obs_errs[0], 0);
    wait_idle("t6_idle", 100);
`else
    // No watchdog: WAIT holds until done arrives, and err stays low.
    ready_mode = 1;
    push_req(13, 0, 1'b1);
    for (int i = 0; i < 20 && keccak_start_o !== 1'b1; i++) tick();
    chk("t6_start_seen", keccak_start_o, 1);
    repeat (40) tick();
    chk("t6_still_waiting", result_valid_o, 0);
    chk("t6_busy", busy_o, 1);
    obs_ids.delete();
    obs_errs.delete();
    keccak_done_i = 1'b1;
    tick();
    keccak_done_i = 1'b0;
    chk("t6_valid", result_valid_o, 1);
    chk("t6_err", result_err_o, 0);
    wait_results(1, 20);
    exp = '{13};
    cmp_ids("t6_result", exp);
    wait_idle("t6_idle", 100);
`endif

    // Randomized traffic against the in-order retirement model.
    obs_ids.delete();
    obs_errs.delete();
    model.delete();
    start_cnt = 0;
    store_cnt = 0;
    done_cnt = 0;
    auto_done = 1'b1;
    ready_mode = 2;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid_i = 1'b0;
      commit_valid_i = 1'b0;
      commit_kill_i = 1'b0;
      if (req_ready_o === 1'b1 && $urandom_range(0, 1) == 1) begin
        ment_t m;
        m.id = $urandom_range(0, 7);
        m.op = $urandom_range(0, 1);
        m.res = 0;
        req_valid_i = 1'b1;
        req_id_i = ID_W'(m.id);
        req_op_i = 1'(m.op);
        model.push_back(m);
      end
      if ($urandom_range(0, 2) == 0) begin
        int cid;
        bit kill;
        cid = $urandom_range(0, 7);
        kill = ($urandom_range(0, 3) == 0);
        commit_valid_i = 1'b1;
        commit_id_i = ID_W'(cid);
        commit_kill_i = kill;
        foreach (model[k]) begin
          if (model[k].res == 0 && model[k].id == cid) model[k].res = kill ? 2 : 1;
        end
      end
      tick();
    end
    req_valid_i = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i = 1'b0;
    forever begin
      first = -1;
      foreach (model[k]) begin
        if (first < 0 && model[k].res == 0) first = k;
      end
      if (first < 0) break;
      foreach (model[k]) begin
        if (model[k].res == 0 && model[k].id == model[first].id) model[k].res = 1;
      end
      commit_req(model[first].id, 1'b0);
    end
    ready_mode = 1;
    wait_idle("rand_idle", 4000);
    exp.delete();
    exp_starts = 0;
    exp_stores = 0;
    foreach (model[k]) begin
      if (model[k].res == 1) begin
        exp.push_back(model[k].id);
        if (model[k].op == 0) exp_starts++;
        else exp_stores++;
      end
    end
    cmp_ids("rand_order", exp);
    chk("rand_starts", start_cnt, exp_starts);
    chk("rand_stores", store_cnt, exp_stores);
`ifndef KECCAK_SCHED_WATCHDOG_EN
    foreach (obs_errs[k]) begin
      if (obs_errs[k] != 0) chk("rand_err", obs_errs[k], 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
